// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath-control outputs of the multicycle control unit.
// master drives the instruction fields and ALU flags; slave is the controller.
interface multicycle_ctrl_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUControl;
   logic [3:0] Flags;
   logic [3:0] State;

   modport master (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, State
   );

   modport slave (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, State
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control FSM with NZCV flag register and condition-gated writes.
// Latency: branch 3, data-proc 4, STR 4, LDR 5 cycles; no backpressure, fixed sequencing.
module multicycle_ctrl #(
   parameter logic [3:0] FLAGS_RST  = 4'b0000,
   parameter logic       COND_UNDEF = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   multicycle_ctrl_if.slave bus
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXECR  = 4'd6, S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8, S_BRANCH = 4'd9
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_flags, w_flags_nxt;
   logic       w_condex, w_condex_nxt, w_is_exec, w_no_write;
   logic [1:0] w_alu_cmd;

   logic       r_pc_write, r_adr_src, r_mem_write, r_ir_write, r_reg_write, r_alu_src_a;
   logic [1:0] r_result_src, r_alu_src_b, r_alu_ctrl;
   logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write, w_alu_src_a;
   logic [1:0] w_result_src, w_alu_src_b, w_alu_ctrl;

   // flags packed {Z,C,N,V}
   function automatic logic f_condex(input logic [3:0] cond, input logic [3:0] flags);
      logic z, c, n, v;
      {z, c, n, v} = flags;
      case (cond)
         4'h0:    return z;
         4'h1:    return ~z;
         4'h2:    return c;
         4'h3:    return ~c;
         4'h4:    return n;
         4'h5:    return ~n;
         4'h6:    return v;
         4'h7:    return ~v;
         4'h8:    return c & ~z;
         4'h9:    return ~(c & ~z);
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return ~z & (n == v);
         4'hD:    return ~(~z & (n == v));
         4'hE:    return 1'b1;
         default: return COND_UNDEF;
      endcase
   endfunction

   always_comb begin
      w_state_nxt = S_FETCH;
      case (r_state)
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               2'b00:   w_state_nxt = bus.Funct[5] ? S_EXECI : S_EXECR;
               2'b01:   w_state_nxt = S_MEMADR;
               2'b10:   w_state_nxt = S_BRANCH;
               default: w_state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: w_state_nxt = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_state_nxt = S_MEMWB;
         S_EXECR,
         S_EXECI:  w_state_nxt = S_ALUWB;
         default:  w_state_nxt = S_FETCH;
      endcase
   end

   assign w_is_exec = (r_state == S_EXECR) || (r_state == S_EXECI);
   assign w_condex  = f_condex(bus.Cond, r_flags);

   always_comb begin
      w_flags_nxt = r_flags;
      if (w_is_exec && w_condex && bus.Funct[0]) begin
         w_flags_nxt[3] = bus.ALUFlags[3];
         w_flags_nxt[1] = bus.ALUFlags[1];
         if (!r_alu_ctrl[1]) begin
            w_flags_nxt[2] = bus.ALUFlags[2];
            w_flags_nxt[0] = bus.ALUFlags[0];
         end
      end
   end

   // Outputs are registered, so gating looks ahead at the flags the next state will see.
   assign w_condex_nxt = f_condex(bus.Cond, w_flags_nxt);
   assign w_no_write   = (bus.Funct[4:1] == 4'b1010);

   always_comb begin
      case (bus.Funct[4:1])
         4'b0100: w_alu_cmd = 2'b00;
         4'b0010: w_alu_cmd = 2'b01;
         4'b1010: w_alu_cmd = 2'b01;
         4'b0000: w_alu_cmd = 2'b10;
         4'b1100: w_alu_cmd = 2'b11;
         default: w_alu_cmd = 2'b00;
      endcase
   end

   always_comb begin
      w_pc_write   = 1'b0;
      w_adr_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = 1'b0;
      w_result_src = 2'b00;
      w_alu_src_b  = 2'b00;
      w_alu_ctrl   = 2'b00;
      case (w_state_nxt)
         S_FETCH: begin
            w_ir_write   = 1'b1;
            w_pc_write   = 1'b1;
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
         end
         S_DECODE: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
         end
         S_MEMADR: w_alu_src_b = 2'b01;
         S_MEMRD:  w_adr_src   = 1'b1;
         S_MEMWB: begin
            w_result_src = 2'b01;
            w_reg_write  = w_condex_nxt;
         end
         S_MEMWR: begin
            w_adr_src   = 1'b1;
            w_mem_write = w_condex_nxt;
         end
         S_EXECR: w_alu_ctrl = w_alu_cmd;
         S_EXECI: begin
            w_alu_src_b = 2'b01;
            w_alu_ctrl  = w_alu_cmd;
         end
         S_ALUWB: begin
            w_reg_write = w_condex_nxt & ~w_no_write;
            w_pc_write  = w_condex_nxt & ~w_no_write & (bus.Rd == 4'd15);
         end
         S_BRANCH: begin
            w_alu_src_b  = 2'b01;
            w_result_src = 2'b10;
            w_pc_write   = w_condex_nxt;
         end
         default: ;
      endcase
   end

   // Output registers reset to the FETCH decode; the reset mask below hides them until release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_FETCH;
         r_flags      <= FLAGS_RST;
         r_pc_write   <= 1'b1;
         r_adr_src    <= 1'b0;
         r_mem_write  <= 1'b0;
         r_ir_write   <= 1'b1;
         r_reg_write  <= 1'b0;
         r_alu_src_a  <= 1'b1;
         r_result_src <= 2'b10;
         r_alu_src_b  <= 2'b10;
         r_alu_ctrl   <= 2'b00;
      end else begin
         r_state      <= w_state_nxt;
         r_flags      <= w_flags_nxt;
         r_pc_write   <= w_pc_write;
         r_adr_src    <= w_adr_src;
         r_mem_write  <= w_mem_write;
         r_ir_write   <= w_ir_write;
         r_reg_write  <= w_reg_write;
         r_alu_src_a  <= w_alu_src_a;
         r_result_src <= w_result_src;
         r_alu_src_b  <= w_alu_src_b;
         r_alu_ctrl   <= w_alu_ctrl;
      end
   end

   assign bus.PCWrite    = r_pc_write & ~reset;
   assign bus.AdrSrc     = r_adr_src & ~reset;
   assign bus.MemWrite   = r_mem_write & ~reset;
   assign bus.IRWrite    = r_ir_write & ~reset;
   assign bus.RegWrite   = r_reg_write & ~reset;
   assign bus.ALUSrcA    = r_alu_src_a & ~reset;
   assign bus.ResultSrc  = reset ? 2'b00 : r_result_src;
   assign bus.ALUSrcB    = reset ? 2'b00 : r_alu_src_b;
   assign bus.ALUControl = reset ? 2'b00 : r_alu_ctrl;
   assign bus.ImmSrc     = reset ? 2'b00 : bus.Op;
   assign bus.RegSrc     = reset ? 2'b00 : {bus.Op == 2'b01, bus.Op == 2'b10};
   assign bus.Flags      = r_flags;
   assign bus.State      = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instructions checked per cycle
// against an instruction-level model of path, gating and flag updates.
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_ctrl_if bus ();
   multicycle_ctrl #(.FLAGS_RST(4'b0000), .COND_UNDEF(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   localparam int FE = 0, DE = 1, MA = 2, MR = 3, MB = 4, MW = 5, ER = 6, EI = 7, AW = 8, BR = 9;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [3:0] m_flags = 4'b0000;

   // condition = base predicate selected by cond[3:1], inverted by cond[0]
   function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
      logic z, cf, n, v, b;
      {z, cf, n, v} = f;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0:    b = z;
         3'd1:    b = cf;
         3'd2:    b = n;
         3'd3:    b = v;
         3'd4:    b = cf & ~z;
         3'd5:    b = (n == v);
         3'd6:    b = ~z & (n == v);
         default: b = 1'b1;
      endcase
      return b ^ c[0];
   endfunction

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}
   function automatic logic [11:0] m_out(input int st, input logic g, input logic [3:0] cmd,
                                         input logic [3:0] rd);
      logic       pc, adr, mem, ir, rw, sa, nw;
      logic [1:0] res, sb, ac;
      pc = 0; adr = 0; mem = 0; ir = 0; rw = 0; sa = 0; res = 0; sb = 0; ac = 0;
      nw = (cmd == 4'b1010);
      case (st)
         FE: begin ir = 1; pc = 1; sa = 1; sb = 2'b10; res = 2'b10; end
         DE: begin sa = 1; sb = 2'b10; res = 2'b10; end
         MA: sb = 2'b01;
         MR: adr = 1;
         MB: begin res = 2'b01; rw = g; end
         MW: begin adr = 1; mem = g; end
         ER, EI: begin
            sb = (st == EI) ? 2'b01 : 2'b00;
            if (cmd == 4'b0000)                        ac = 2'b10;
            else if (cmd == 4'b1100)                   ac = 2'b11;
            else if (cmd == 4'b0010 || cmd == 4'b1010) ac = 2'b01;
            else                                       ac = 2'b00;
         end
         AW: begin rw = g & ~nw; pc = g & ~nw & (rd == 4'd15); end
         BR: begin sb = 2'b01; res = 2'b10; pc = g; end
         default: ;
      endcase
      return {pc, adr, mem, ir, rw, res, sa, sb, ac};
   endfunction

   function automatic logic [11:0] act_out();
      return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
              bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl};
   endfunction

   // Entered just after a rising edge with the DUT in FETCH; returns the same way.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                            input logic [3:0] rd, input logic [3:0] af, input string name);
      int         path[$];
      logic       ok_pre, ok_post, g, past_exec;
      logic [3:0] nf, exp_f;
      logic [11:0] exp_o;
      bus.Cond = c; bus.Op = op; bus.Funct = fn; bus.Rd = rd; bus.ALUFlags = af;
      path.push_back(FE);
      path.push_back(DE);
      case (op)
         2'b00: begin path.push_back(fn[5] ? EI : ER); path.push_back(AW); end
         2'b01: begin
            path.push_back(MA);
            if (fn[0]) begin path.push_back(MR); path.push_back(MB); end
            else path.push_back(MW);
         end
         2'b10: path.push_back(BR);
         default: ;
      endcase
      ok_pre = m_cond(c, m_flags);
      nf = m_flags;
      if (op == 2'b00 && ok_pre && fn[0]) begin
         nf[3] = af[3];
         nf[1] = af[1];
         if (!(fn[4:1] == 4'b0000 || fn[4:1] == 4'b1100)) begin
            nf[2] = af[2];
            nf[0] = af[0];
         end
      end
      ok_post = m_cond(c, nf);
      past_exec = 1'b0;
      for (int i = 0; i < path.size(); i++) begin
         @(negedge clk);
         g     = (path[i] == AW) ? ok_post : ok_pre;
         exp_o = m_out(path[i], g, fn[4:1], rd);
         exp_f = past_exec ? nf : m_flags;
         n_tests++;
         if (bus.State !== 4'(path[i])) begin
            n_fail++;
            $display("FAIL %s state c%0d: got %0d want %0d", name, i, bus.State, path[i]);
         end
         n_tests++;
         if (act_out() !== exp_o) begin
            n_fail++;
            $display("FAIL %s outputs st%0d: got %b want %b", name, path[i], act_out(), exp_o);
         end
         n_tests++;
         if (bus.Flags !== exp_f) begin
            n_fail++;
            $display("FAIL %s flags st%0d: got %b want %b", name, path[i], bus.Flags, exp_f);
         end
         if (path[i] == DE) begin
            n_tests++;
            if ({bus.ImmSrc, bus.RegSrc} !== {op, op == 2'b01, op == 2'b10}) begin
               n_fail++;
               $display("FAIL %s imm/regsrc: got %b%b want %b%b%b", name, bus.ImmSrc,
                        bus.RegSrc, op, op == 2'b01, op == 2'b10);
            end
         end
         @(posedge clk);
         #1;
         if (path[i] == ER || path[i] == EI) past_exec = 1'b1;
      end
      m_flags = nf;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.State !== 4'd0 || act_out() !== 12'd0 || bus.Flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_state: got st=%0d out=%b fl=%b want 0/0/0", bus.State, act_out(),
                  bus.Flags);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      n_tests++;
      if (act_out() !== m_out(FE, 1'b1, 4'd0, 4'd0)) begin
         n_fail++;
         $display("FAIL reset_release: got %b want %b", act_out(), m_out(FE, 1'b1, 4'd0, 4'd0));
      end
      m_flags = 4'b0000;
   endtask

   task automatic test_flags_branch();
      run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b1000, "adds_z");
      n_tests++;
      if (bus.Flags !== 4'b1000) begin
         n_fail++;
         $display("FAIL adds_z_flags: got %b want 1000", bus.Flags);
      end
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, "beq_taken");
      run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0000, "adds_clear");
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, "beq_not_taken");
   endtask

   task automatic test_cmp();
      run_instr(4'hE, 2'b00, 6'b010101, 4'd3, 4'b0010, "cmp");
      n_tests++;
      if (bus.Flags !== 4'b0010) begin
         n_fail++;
         $display("FAIL cmp_flags: got %b want 0010", bus.Flags);
      end
   endtask

   task automatic test_logical_flags();
      run_instr(4'hE, 2'b00, 6'b101001, 4'd4, 4'b0100, "adds_c");
      run_instr(4'hE, 2'b00, 6'b100001, 4'd5, 4'b0111, "ands");
      n_tests++;
      if (bus.Flags !== 4'b0110) begin
         n_fail++;
         $display("FAIL ands_flags: got %b want 0110", bus.Flags);
      end
      run_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'b1111, "add_pc");
   endtask

   task automatic test_mem();
      run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b1000, "adds_z2");
      run_instr(4'h1, 2'b01, 6'b011000, 4'd2, 4'b0000, "strne");
      run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, "ldr");
      run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, "op11");
   endtask

   task automatic test_reset_midinstr();
      run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b1111, "adds_all");
      bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd2;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (bus.State !== 4'(MR)) begin
         n_fail++;
         $display("FAIL mid_reach_memrd: got %0d want %0d", bus.State, MR);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (bus.State !== 4'd0 || act_out() !== 12'd0 || bus.Flags !== 4'b0000 ||
          {bus.ImmSrc, bus.RegSrc} !== 4'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got st=%0d out=%b fl=%b want 0/0/0", bus.State, act_out(),
                  bus.Flags);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      n_tests++;
      if (bus.State !== 4'd0 || bus.IRWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_release: got st=%0d ir=%b want 0/1", bus.State, bus.IRWrite);
      end
      m_flags = 4'b0000;
   endtask

   task automatic test_random();
      logic [1:0] op;
      logic [3:0] rd;
      for (int k = 0; k < 60; k++) begin
         op = 2'($urandom_range(0, 3));
         rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         run_instr(4'($urandom_range(0, 15)), op, 6'($urandom_range(0, 63)), rd,
                   4'($urandom_range(0, 15)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_flags_branch();
      test_cmp();
      test_logical_flags();
      test_mem();
      test_reset_midinstr();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
